// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexes two hex nibbles onto a dual-digit common-segment 7-seg display
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   nibbleMS   most significant digit value
//   nibbleLS   least significant digit value
//   lzBlank    blank the MS digit when its captured value is zero
//   seg        segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   digitSel   0 = LS digit, 1 = MS digit, polarity set by SEG_ACTIVE_LOW
//   frameTick  one-cycle pulse on the first LS_ON cycle of each frame
module seven_seg_mux #(
    parameter int DIGIT_CYCLES   = 6000,
    parameter int BLANK_CYCLES   = 120,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] nibbleMS,
    input  logic [3:0] nibbleLS,
    input  logic       lzBlank,
    output logic [6:0] seg,
    output logic       digitSel,
    output logic       frameTick
);
    localparam int MAX_DWELL = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_DWELL);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    // Encoding order is the frame order, so advancing is a 2-bit increment that wraps.
    typedef enum logic [1:0] {LS_ON, BLANK_A, MS_ON, BLANK_B} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    shadow_ms, shadow_ls, cap_ms, cap_ls;
    logic [6:0]    seg_r, seg_d;
    logic          sel_r, tick_r, done, entering_ls;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    always_comb begin
        done        = cnt == ((state == LS_ON || state == MS_ON) ? DIGIT_LAST : BLANK_LAST);
        nxt         = done ? state_t'(state + 2'd1) : state;
        entering_ls = nxt == LS_ON && state != LS_ON;
        // Capture values are used directly so the first LS_ON cycle already shows the new frame.
        cap_ls      = entering_ls ? nibbleLS : shadow_ls;
        cap_ms      = entering_ls ? nibbleMS : shadow_ms;
        seg_d       = nxt == LS_ON ? decode(cap_ls) :
                      (nxt == MS_ON && !(lzBlank && cap_ms == 4'h0)) ? decode(cap_ms) : 7'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BLANK_B;
            cnt       <= '0;
            shadow_ms <= 4'h0;
            shadow_ls <= 4'h0;
            seg_r     <= 7'h00;
            sel_r     <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= done ? '0 : cnt + CW'(1);
            shadow_ms <= cap_ms;
            shadow_ls <= cap_ls;
            seg_r     <= seg_d;
            sel_r     <= nxt == BLANK_A || nxt == MS_ON;
            tick_r    <= entering_ls;
        end
    end

    assign seg       = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
    assign digitSel  = SEG_ACTIVE_LOW ? ~sel_r : sel_r;
    assign frameTick = tick_r;
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed self-checking bench for seven_seg_mux (active-high and active-low instances)
module tb_seven_seg_mux;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] nibbleMS = 4'h4;
    logic [3:0] nibbleLS = 4'h2;
    logic       lzBlank = 1'b0;
    logic [6:0] seg, seg_n;
    logic       digitSel, digitSel_n, frameTick, frameTick_n;
    int         checks = 0;
    int         errors = 0;

    localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seven_seg_mux #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .nibbleMS(nibbleMS), .nibbleLS(nibbleLS), .lzBlank(lzBlank),
        .seg(seg), .digitSel(digitSel), .frameTick(frameTick));

    seven_seg_mux #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst(rst), .nibbleMS(nibbleMS), .nibbleLS(nibbleLS), .lzBlank(lzBlank),
        .seg(seg_n), .digitSel(digitSel_n), .frameTick(frameTick_n));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [6:0] s, input logic d, input logic t);
        chk({tag, " seg"}, seg, s);
        chk({tag, " sel"}, {6'd0, digitSel}, {6'd0, d});
        chk({tag, " tick"}, {6'd0, frameTick}, {6'd0, t});
        chk({tag, " seg_n"}, seg_n, ~s);
        chk({tag, " sel_n"}, {6'd0, digitSel_n}, {6'd0, ~d});
        chk({tag, " tick_n"}, {6'd0, frameTick_n}, {6'd0, t});
    endtask

    // Called just before the edge that enters LS_ON; returns after the last BLANK_B cycle.
    // If chg_at >= 0, nibbleLS is changed to chg_val after that LS_ON cycle is sampled.
    task automatic frame(input string tag, input logic [6:0] ls_seg, input logic [6:0] ms_seg,
                         input int chg_at, input logic [3:0] chg_val);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i < 8)       chk_all({tag, " ls_on"},   ls_seg, 1'b0, i == 0);
            else if (i < 10) chk_all({tag, " blank_a"}, 7'h00,  1'b1, 1'b0);
            else if (i < 18) chk_all({tag, " ms_on"},   ms_seg, 1'b1, 1'b0);
            else             chk_all({tag, " blank_b"}, 7'h00,  1'b0, 1'b0);
            if (i == chg_at) nibbleLS = chg_val;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("reset", 7'h00, 1'b0, 1'b0);
        end
        rst = 1'b0;
        step();
        chk_all("post_reset blank_b", 7'h00, 1'b0, 1'b0);
        frame("basic", DEC[2], DEC[4], -1, 4'h0);
        for (int v = 0; v < 16; v++) begin
            nibbleMS = 4'(v);
            nibbleLS = 4'(v);
            frame($sformatf("sweep%0d", v), DEC[v], DEC[v], -1, 4'h0);
        end
        nibbleMS = 4'h1;
        nibbleLS = 4'h3;
        frame("tear", 7'h4F, 7'h06, 3, 4'h7);
        frame("tear_next", 7'h07, 7'h06, -1, 4'h0);
        nibbleMS = 4'h0;
        lzBlank  = 1'b1;
        frame("lz_on", 7'h07, 7'h00, -1, 4'h0);
        lzBlank  = 1'b0;
        frame("lz_off", 7'h07, 7'h3F, -1, 4'h0);
        nibbleMS = 4'h5;
        nibbleLS = 4'h9;
        for (int i = 0; i < 15; i++) step();
        chk_all("pre_abort ms_on", 7'h6D, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        chk_all("abort", 7'h00, 1'b0, 1'b0);
        rst = 1'b0;
        nibbleMS = 4'hA;
        nibbleLS = 4'hC;
        step();
        chk_all("abort blank_b", 7'h00, 1'b0, 1'b0);
        frame("after_abort", 7'h39, 7'h77, -1, 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
